// File: rtl/popcount_seq.sv
// Wide-word popcount that time-shares one sum8 unit, one byte per cycle.
// Latency: result valid N/8 cycles after the accept edge; one word per N/8+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.

module sum8 (
  input  logic [7:0] dat,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, dat[i]};
    end
  end

endmodule

module popcount_seq #(
  parameter int N  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  localparam int NB = N / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  wreg;
  logic [IW-1:0] idx;
  logic [CW-1:0] acc;
  logic [7:0]    byte_dat;
  logic [3:0]    byte_cnt;
  logic          accept;

  assign accept = in_valid && in_ready;

  // Byte lane select as an explicit mux so no index can run past the word.
  always_comb begin
    byte_dat = '0;
    for (int b = 0; b < NB; b++) begin
      if (idx == IW'(b)) begin
        byte_dat = wreg[b*8 +: 8];
      end
    end
  end

  sum8 u_sum8 (
    .dat (byte_dat),
    .cnt (byte_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = BUSY;
      BUSY:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wreg <= '0;
      acc  <= '0;
      idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wreg <= in_data;
            acc  <= '0;
            idx  <= '0;
          end
        end
        BUSY: begin
          // Max total is N, which CW bits always hold, so no carry-out to lose.
          acc <= acc + CW'(byte_cnt);
          idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    busy      = (state == BUSY);
    out_valid = (state == DONE);
    out_count = acc;
  end

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq (N=32): directed table, corner sequences, random sweep.
module tb_popcount_seq;

  localparam int N  = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  popcount_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_pop(input logic [31:0] w);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'((w >> i) & 32'd1);
    return s;
  endfunction

  // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
  task automatic accept_word(input logic [31:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check("result_timeout", 0, 1);
  endtask

  task automatic run_word(input logic [31:0] d, input int exp, input string name, input int stall);
    int lat;
    accept_word(d);
    wait_out(lat);
    check({name, "_latency"}, lat, 4);
    for (int s = 0; s < stall; s++) @(negedge clk);
    check({name, "_count"}, out_count, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    vec_t vecs[$];
    int   lat;
    int   res_q[$];
    int   cyc_q[$];
    int   cyc;
    int   widx;
    logic [31:0] words[3];

    vecs.push_back('{32'hFFFF_FFFF, 32, "all_ones"});
    vecs.push_back('{32'h8000_0001, 2,  "ends"});
    vecs.push_back('{32'h0F0F_00FF, 16, "mixed"});
    vecs.push_back('{32'hAAAA_AAAA, 16, "alt"});
    vecs.push_back('{32'h0001_0000, 1,  "single"});

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_count", out_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // First word: cycle-by-cycle handshake timing
    in_valid = 1'b1;
    in_data  = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("zero_busy_c%0d", k), busy, 1);
      check($sformatf("zero_in_ready_c%0d", k), in_ready, 0);
      check($sformatf("zero_out_valid_c%0d", k), out_valid, 0);
      @(negedge clk);
    end
    check("zero_out_valid", out_valid, 1);
    check("zero_busy_done", busy, 0);
    check("zero_count", out_count, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("zero_in_ready_after", in_ready, 1);

    // Directed table
    foreach (vecs[i]) run_word(vecs[i].data, vecs[i].exp, vecs[i].name, 0);

    // Held result under backpressure while the producer keeps offering a word
    accept_word(32'h8000_0001);
    wait_out(lat);
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_count_c%0d", k), out_count, 2);
      check($sformatf("stall_in_ready_c%0d", k), in_ready, 0);
      check($sformatf("stall_out_valid_c%0d", k), out_valid, 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_in_ready", in_ready, 1);
    check("stall_release_out_valid", out_valid, 0);

    // Back-to-back with both sides always willing
    words[0] = 32'h1; words[1] = 32'h3; words[2] = 32'h7;
    widx = 0;
    cyc = 0;
    in_valid  = 1'b1;
    in_data   = words[0];
    out_ready = 1'b1;
    while (res_q.size() < 3 && cyc < 60) begin
      logic take;
      take = in_valid && in_ready;
      if (out_valid) begin
        res_q.push_back(int'(out_count));
        cyc_q.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
      if (take) begin
        widx++;
        if (widx < 3) in_data = words[widx];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", res_q.size(), 3);
    for (int i = 0; i < res_q.size(); i++) check($sformatf("b2b_res%0d", i), res_q[i], i + 1);
    for (int i = 1; i < cyc_q.size(); i++) check($sformatf("b2b_gap%0d", i), cyc_q[i] - cyc_q[i-1], 6);
    @(negedge clk);

    // Asynchronous reset in the third BUSY cycle
    accept_word(32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_out_count", out_count, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) check("arst_stale_result", out_valid, 0);
      @(negedge clk);
    end
    run_word(32'h0000_00FF, 8, "post_arst", 0);

    // Single-byte patterns in every lane, then random words with random stalls
    for (int lane = 0; lane < 4; lane++) begin
      for (int v = 0; v < 256; v++) begin
        logic [31:0] w;
        w = 32'(v) << (8 * lane);
        run_word(w, ref_pop(w), $sformatf("lane%0d_%0d", lane, v), 0);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] w;
      w = $urandom;
      run_word(w, ref_pop(w), $sformatf("rand%0d", i), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
